// File: rtl/counter_sequencer.sv
// Purpose: round-robin arbiter that lends one shared W-bit loadable up-counter to NREQ requesters (LOAD or COUNT).
// Latency: from the IDLE cycle that samples req, ack arrives 3 cycles later for LOAD, k+2 for COUNT k>0, 1 for COUNT 0.
// Backpressure: requests are level-held until ack; req is sampled only in IDLE, so one operation is in flight at a time.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req/req_op/req_arg  per-requester request level, op (0 LOAD, 1 COUNT), W-bit argument slice
//   ack, result         one-hot completion pulse and final counter value (held until next ack)
//   busy                high whenever an operation is in progress
//   cnt_load/en/d/q     control and value of the shared counter
module counter_sequencer #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_op,
  input  logic [NREQ*W-1:0]   req_arg,
  output logic [NREQ-1:0]     ack,
  output logic [W-1:0]        result,
  output logic                busy,
  output logic                cnt_load,
  output logic                cnt_en,
  output logic [W-1:0]        cnt_d,
  input  logic [W-1:0]        cnt_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic            op_q, op_nxt;
  logic [W-1:0]    arg_q, arg_nxt;
  logic [W-1:0]    rem_q, rem_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [W-1:0]    result_nxt;

  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [W-1:0]    gnt_arg;

  // First set req bit at or above rr_ptr, wrapping back to 0.
  always_comb begin : grant_search
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && req[j[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
  end

  assign gnt_arg = req_arg[gnt_idx*W +: W];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      idx_q  <= '0;
      op_q   <= 1'b0;
      arg_q  <= '0;
      rem_q  <= '0;
      ack    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      idx_q  <= idx_nxt;
      op_q   <= op_nxt;
      arg_q  <= arg_nxt;
      rem_q  <= rem_nxt;
      ack    <= ack_nxt;
      result <= result_nxt;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    idx_nxt    = idx_q;
    op_nxt     = op_q;
    arg_nxt    = arg_q;
    rem_nxt    = rem_q;
    ack_nxt    = '0;
    result_nxt = result;

    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          idx_nxt = gnt_idx;
          op_nxt  = req_op[gnt_idx];
          arg_nxt = gnt_arg;
          rr_nxt  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
          if (!req_op[gnt_idx]) begin
            state_nxt = ST_LOAD;
          end else if (gnt_arg != '0) begin
            state_nxt = ST_COUNT;
            rem_nxt   = gnt_arg;
          end else begin
            // COUNT 0 touches nothing: report the current value straight away.
            state_nxt          = ST_ACK;
            result_nxt         = cnt_q;
            ack_nxt[gnt_idx]   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_nxt = ST_WAIT;
      end
      ST_COUNT: begin
        rem_nxt = rem_q - W'(1);
        if (rem_q == W'(1)) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter has absorbed the last load/increment; its q is final here.
        result_nxt     = cnt_q;
        ack_nxt[idx_q] = 1'b1;
        state_nxt      = ST_ACK;
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter controls are Moore outputs of the state register.
  // op_q is always 1 in COUNT; gating on it keeps a corrupted state from
  // turning a load into an increment.
  assign cnt_load = (state == ST_LOAD) || (state == ST_COUNT);
  assign cnt_en   = (state == ST_COUNT) && op_q;
  assign cnt_d    = (state == ST_LOAD) ? arg_q : '0;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: shared counter model, table of single transactions,
// hand sequences for round-robin, mid-operation reset and late argument change,
// then random multi-requester traffic against a transaction-level reference model.
module tb_counter_sequencer;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req, req_op;
  logic [NREQ*W-1:0]   req_arg;
  logic [NREQ-1:0]     ack;
  logic [W-1:0]        result;
  logic                busy, cnt_load, cnt_en;
  logic [W-1:0]        cnt_d, cnt_q;

  always #5 clk = ~clk;

  counter_sequencer #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_op(req_op), .req_arg(req_arg),
    .ack(ack), .result(result), .busy(busy),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_d(cnt_d), .cnt_q(cnt_q)
  );

  // The shared counter the sequencer drives.
  always_ff @(posedge clk) begin
    if (reset)          cnt_q <= '0;
    else if (cnt_load)  cnt_q <= cnt_en ? cnt_q + W'(1) : cnt_d;
  end

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input int arg);
    req[i]             = 1'b1;
    req_op[i]          = op;
    req_arg[i*W +: W]  = W'(arg);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    req_op  = '0;
    req_arg = '0;
    tick();
    tick();
    reset   = 1'b0;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Steps until ack appears (bounded). Collects counter activity seen on the way.
  task automatic wait_ack(input int chg_idx, input int chg_arg,
                          output int g, output int lat, output int ens,
                          output int lds, output int bad_ctl, output logic [W-1:0] ld_d);
    g = -1; lat = 0; ens = 0; lds = 0; bad_ctl = 0; ld_d = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1 && chg_idx >= 0) req_arg[chg_idx*W +: W] = W'(chg_arg);
      if (!busy) bad_ctl++;
      if (ack != '0) begin
        if (cnt_load || cnt_en) bad_ctl++;
        lat = c;
        g   = $onehot(ack) ? idx_of(ack) : -2;
        break;
      end
      if (cnt_en) begin
        ens++;
        if (!cnt_load || cnt_d != '0) bad_ctl++;
      end else if (cnt_load) begin
        lds++;
        ld_d = cnt_d;
      end
    end
    if (g == -1) begin
      ncmp++;
      nbad++;
      $display("FAIL ack_timeout: got ack=0 for 40 cycles, required a one-hot ack");
    end
  endtask

  // One isolated request from an idle sequencer, fully checked.
  task automatic run_one(input string name, input int idx, input logic op, input int arg,
                         input int exp_res, input int exp_lat,
                         input int chg_idx, input int chg_arg);
    int g, lat, ens, lds, bad;
    logic [W-1:0] ldd;
    set_req(idx, op, arg);
    wait_ack(chg_idx, chg_arg, g, lat, ens, lds, bad, ldd);
    req[idx] = 1'b0;
    chk({name, ".grant"}, g, idx);
    chk({name, ".latency"}, lat, exp_lat);
    chk({name, ".result"}, result, exp_res);
    chk({name, ".en_cycles"}, ens, op ? arg : 0);
    chk({name, ".load_cycles"}, lds, op ? 0 : 1);
    if (!op) chk({name, ".load_d"}, ldd, arg);
    chk({name, ".ctl_busy"}, bad, 0);
    tick();
    chk({name, ".ack_cleared"}, ack, 0);
    chk({name, ".result_held"}, result, exp_res);
    chk({name, ".busy_idle"}, busy, 0);
  endtask

  typedef struct {
    int   idx;
    logic op;
    int   arg;
    int   res;
    int   lat;
  } vec_t;

  vec_t tab[8];

  initial begin
    int g, lat, ens, lds, bad;
    logic [W-1:0] ldd;
    int exp_g[7];
    int acks;
    int mq, mrr, eg, eres, elat, npend;
    logic [NREQ-1:0] pend;
    logic pop[NREQ];
    int   parg[NREQ];

    // Sequence of isolated requests; counter value carries from one to the next.
    tab[0] = '{0, 1'b0,  9,  9,  3};
    tab[1] = '{1, 1'b0, 14, 14,  3};
    tab[2] = '{2, 1'b1,  3,  1,  5};   // 14 + 3 wraps to 1
    tab[3] = '{3, 1'b0,  5,  5,  3};
    tab[4] = '{1, 1'b1,  0,  5,  1};   // COUNT 0: no counter activity
    tab[5] = '{0, 1'b1, 15,  4, 17};   // 5 + 15 wraps to 4
    tab[6] = '{2, 1'b0,  0,  0,  3};
    tab[7] = '{3, 1'b1,  1,  1,  3};

    reset   = 1'b1;
    req     = '0;
    req_op  = '0;
    req_arg = '0;
    tick();
    tick();
    chk("rst.ack", ack, 0);
    chk("rst.result", result, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cnt_load", cnt_load, 0);
    chk("rst.cnt_en", cnt_en, 0);
    chk("rst.cnt_d", cnt_d, 0);
    reset = 1'b0;
    tick();
    chk("idle.no_req_ctl", {cnt_load, cnt_en, busy}, 0);

    foreach (tab[n])
      run_one($sformatf("vec%0d", n), tab[n].idx, tab[n].op, tab[n].arg,
              tab[n].res, tab[n].lat, -1, 0);

    // Round-robin: all four held (re-raised after each ack), then only 1 and 3.
    do_reset();
    exp_g = '{0, 1, 2, 3, 0, 1, 3};
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 10 + i);
    for (int n = 0; n < 7; n++) begin
      wait_ack(-1, 0, g, lat, ens, lds, bad, ldd);
      chk($sformatf("rr.grant%0d", n), g, exp_g[n]);
      chk($sformatf("rr.result%0d", n), result, 10 + exp_g[n]);
      if (g >= 0) req[g] = 1'b0;
      if (n == 4) req[2] = 1'b0;
      tick();
      tick();
      if (n < 4 && g >= 0) req[g] = 1'b1;
    end

    // Reset during the second COUNT cycle aborts and clears the rr pointer.
    do_reset();
    set_req(2, 1'b0, 3);
    wait_ack(-1, 0, g, lat, ens, lds, bad, ldd);
    req[2] = 1'b0;
    chk("abort.pre_grant", g, 2);
    tick();
    set_req(0, 1'b1, 6);
    tick();
    tick();
    chk("abort.counting", cnt_en, 1);
    reset  = 1'b1;
    req[0] = 1'b0;
    tick();
    chk("abort.outputs", {ack, busy, cnt_load, cnt_en, cnt_d}, 0);
    chk("abort.result", result, 0);
    chk("abort.cnt_q", cnt_q, 0);
    reset = 1'b0;
    acks  = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack != '0) acks++;
    end
    chk("abort.no_ack", acks, 0);
    set_req(0, 1'b1, 2);
    set_req(3, 1'b0, 8);
    wait_ack(-1, 0, g, lat, ens, lds, bad, ldd);
    chk("abort.rr_reset_grant", g, 0);
    chk("abort.result0", result, 2);
    req[0] = 1'b0;
    tick();
    wait_ack(-1, 0, g, lat, ens, lds, bad, ldd);
    chk("abort.next_grant", g, 3);
    chk("abort.result3", result, 8);
    req[3] = 1'b0;
    tick();

    // Argument changed one cycle after the grant must be ignored.
    run_one("argchg", 3, 1'b0, 7, 7, 3, 3, 2);

    // Random traffic against a transaction-level model.
    do_reset();
    mq   = 0;
    mrr  = 0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i]  = 1'b0;
      parg[i] = 0;
    end
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pop[i]  = 1'($urandom_range(0, 1));
          parg[i] = int'($urandom_range(0, 15));
          set_req(i, pop[i], parg[i]);
        end
      end
      npend = $countones(pend);
      if (npend == 0) begin
        tick();
        chk("rand.idle_ack", ack, 0);
        continue;
      end
      eg = -1;
      for (int k = 0; k < NREQ; k++)
        if (eg < 0 && pend[(mrr + k) % NREQ]) eg = (mrr + k) % NREQ;
      if (pop[eg]) begin
        eres = (mq + parg[eg]) % (1 << W);
        elat = (parg[eg] == 0) ? 1 : parg[eg] + 2;
      end else begin
        eres = parg[eg];
        elat = 3;
      end
      wait_ack(-1, 0, g, lat, ens, lds, bad, ldd);
      chk($sformatf("rand%0d.grant", t), g, eg);
      chk($sformatf("rand%0d.result", t), result, eres);
      chk($sformatf("rand%0d.latency", t), lat, elat);
      chk($sformatf("rand%0d.en_cycles", t), ens, pop[eg] ? parg[eg] : 0);
      chk($sformatf("rand%0d.load_cycles", t), lds, pop[eg] ? 0 : 1);
      chk($sformatf("rand%0d.ctl_busy", t), bad, 0);
      mq       = eres;
      mrr      = (eg + 1) % NREQ;
      pend[eg] = 1'b0;
      req[eg]  = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Round-robin scheduler that shares one 4-bit loadable up-counter among NREQ requesters.
Each requester asks for one of two operations: LOAD a value, or COUNT a given number of increments.
The block grants one request at a time, drives the counter's load/en/d controls, captures the final counter value and returns it with a one-cycle ack.
It sits between requesting agents and the shared counter instance, and owns that counter's control inputs exclusively.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, counter width; must match the shared counter

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level; held until ack
req_op  input  NREQ  per-requester operation; 0 = LOAD, 1 = COUNT
req_arg  input  NREQ*W  per-requester argument; slice i is bits [i*W+W-1 : i*W]; LOAD value or increment count
ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester
result  output  W  counter value after the operation; valid while ack is high, held until the next ack
busy  output  1  high whenever state is not IDLE
cnt_load  output  1  to the counter's load input
cnt_en  output  1  to the counter's en input
cnt_d  output  W  to the counter's d input
cnt_q  input  W  from the counter's q output

Behaviour:
- Counter contract:
  - load=1, en=0: q <= d next edge.
  - load=1, en=1: q <= q+1, wrapping mod 2^W.
  - load=0: q holds.
  - The counter shares reset and clears to 0.
- States: IDLE, LOAD, COUNT, WAIT, ACK. The cnt_* outputs are decoded from the state register only (Moore).
- Reset values:
  - state=IDLE, rr pointer=0, ack=0, result=0, busy=0.
  - cnt_load=0, cnt_en=0, cnt_d=0.
  - Latched index, op and arg are 0, and the remaining-count register is 0.
  - Reset mid-operation aborts at once; no ack is issued for the aborted request.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, grant the first set bit searching from the rr pointer upward with wrap. After reset the pointer is 0, giving priority 0,1,..,NREQ-1.
  - Latch the index, req_op and req_arg slice; set rr pointer = (granted index + 1) mod NREQ.
  - Next state:
    - LOAD if op=0.
    - COUNT if op=1 and arg≠0, with remaining = arg.
    - ACK if op=1 and arg=0; result <= cnt_q and ack is registered on this same edge.
  - With no req set, stay in IDLE with counter controls 0.
- LOAD:
  - One cycle with cnt_load=1, cnt_en=0, cnt_d=latched arg.
  - Next state WAIT.
- COUNT:
  - cnt_load=1, cnt_en=1, cnt_d=0; remaining decrements each cycle.
  - When remaining=1, next state WAIT, giving exactly arg increments.
- WAIT:
  - Controls are 0, and cnt_q now reflects the final value.
  - result <= cnt_q and ack <= onehot(index) on the leaving edge; next state ACK.
- ACK:
  - ack is high for exactly this cycle, and result is valid.
  - Next state IDLE; ack returns to 0.
- Latency, counted from the IDLE cycle that samples req:
  - LOAD: ack 3 cycles later.
  - COUNT k (k≥1): ack k+2 cycles later.
  - COUNT 0: ack 1 cycle later, no counter activity.
- Requester rule:
  - Deassert req on the edge where ack is seen, so req is low in the following IDLE cycle.
  - If req is still high in that cycle, it is a new request.
  - Changes to req, req_op or req_arg after the grant edge are ignored until the next IDLE.
- Simultaneous requests are served one at a time in round-robin order. A requester is never granted twice in a row while another requester's req is high in IDLE.
- Wrap-around: the counter wraps; the sequencer does no saturation. Example: q=14 with COUNT 3 gives result 1.
- Never drive cnt_load/cnt_en outside the LOAD and COUNT states.

Test Plan:
1. Reset, then req[0] LOAD 9 -> cnt_load=1/cnt_en=0/cnt_d=9 for one cycle; ack=0001 three cycles after the sampling IDLE cycle; result=9; busy high throughout.
2. q=14, req[2] COUNT 3 -> cnt_en high exactly 3 cycles; ack=0100 at +5 cycles; result=1 (wrap).
3. req=1111 held and re-raised after each ack -> grants 0,1,2,3,0 in order; then with only req[3] and req[1] raised after grant 0, the grants are 1 then 3.
4. req[1] COUNT 0 with q=5 -> no cnt_load/cnt_en pulse; ack=0010 one cycle later; result=5.
5. Reset asserted during the 2nd cycle of COUNT 6 -> next cycle IDLE, all outputs 0, no ack; the next req[0] grant ignores the old rr pointer.
6. req[3] LOAD 7 with its arg changed to 2 one cycle after grant -> result=7; the change is ignored.
